// File: rtl/magcomp_pkg.sv
// Shared types for the magnitude-compare sequencer:
// states, phase codes, result display encodings.
package magcomp_pkg;

  localparam int HOLD_CYC_DEF = 100_000_000;
  localparam int CNT_W_DEF    = 27;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SHOW_A   = 3'd3,
    ST_SHOW_B   = 3'd4,
    ST_SHOW_RES = 3'd5
  } state_t;

  localparam logic [1:0] PH_NONE = 2'b00;
  localparam logic [1:0] PH_A    = 2'b01;
  localparam logic [1:0] PH_B    = 2'b10;
  localparam logic [1:0] PH_RES  = 2'b11;

  typedef struct packed {
    logic       sign;
    logic [4:0] val;
  } disp_t;

  localparam disp_t RES_GT = disp_t'{1'b0, 5'd1};
  localparam disp_t RES_EQ = disp_t'{1'b0, 5'd0};
  localparam disp_t RES_LT = disp_t'{1'b1, 5'd1};

  function automatic disp_t res_disp(
    input logic eq,
    input logic gt
  );
    disp_t d;
    d = RES_LT;
    unique case (1'b1)
      gt:      d = RES_GT;
      eq:      d = RES_EQ;
      default: d = RES_LT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/magcomp_seq_ctrl_if.sv
// Bundle between sequencer, switches,
// datapath and seven-seg driver.
interface magcomp_seq_ctrl_if;

  logic [4:0] A_IN;
  logic [4:0] B_IN;
  logic       LOAD;
  logic       FREEZE;
  logic [4:0] A_REG;
  logic [4:0] B_REG;
  logic [4:0] A_MAG;
  logic [4:0] B_MAG;
  logic       EQ;
  logic       GT;
  logic [4:0] DISP_VAL;
  logic       DISP_SIGN;
  logic       DISP_VALID;
  logic [1:0] PHASE;
  logic       BUSY;

  modport master (
    input  A_IN, B_IN, LOAD, FREEZE,
    input  A_MAG, B_MAG, EQ, GT,
    output A_REG, B_REG,
    output DISP_VAL, DISP_SIGN, DISP_VALID,
    output PHASE, BUSY
  );

  modport slave (
    output A_IN, B_IN, LOAD, FREEZE,
    output A_MAG, B_MAG, EQ, GT,
    input  A_REG, B_REG,
    input  DISP_VAL, DISP_SIGN, DISP_VALID,
    input  PHASE, BUSY
  );

endinterface

// File: rtl/magcomp_seq_ctrl_phase_timer.sv
// Display hold counter: clear, enable and a
// terminal-count pulse on the last held cycle.
module phase_timer #(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 27
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LP_LAST);

  // clear wins; hold while disabled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/magcomp_seq_ctrl.sv
// Sequencer: capture operands, settle, latch
// compare result, rotate display A/B/RESULT.
module magcomp_seq_ctrl
  import magcomp_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic CLK,
  input logic RST_N,
  magcomp_seq_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_tc;
  logic       w_en;
  logic       w_clr;
  logic       w_show;

  logic [4:0] r_a_reg;
  logic [4:0] r_b_reg;
  logic       r_res_eq;
  logic       r_res_gt;
  logic       r_sgn_a;
  logic       r_sgn_b;

  logic [4:0] r_disp_val;
  logic       r_disp_sign;
  logic       r_disp_valid;
  logic [1:0] r_phase;
  logic       r_busy;

  disp_t      w_disp;
  logic       w_valid;
  logic [1:0] w_phase;
  logic       w_busy;
  logic       w_sgn_a;

  assign w_show = (r_state == ST_SHOW_A) ||
                  (r_state == ST_SHOW_B) ||
                  (r_state == ST_SHOW_RES);
  assign w_en   = w_show && !bus.FREEZE;
  assign w_clr  = (w_next != r_state);

  // sign latch lands with the first SHOW_A cycle
  assign w_sgn_a = (r_state == ST_SETTLE) ?
                   r_a_reg[4] : r_sgn_a;

  phase_timer #(
    .HOLD_CYC (HOLD_CYC),
    .CNT_W    (CNT_W)
  ) u_timer (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_tc  (w_tc)
  );

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state; LOAD beats phase advance
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (bus.LOAD) w_next = ST_CAPTURE;
      ST_CAPTURE:
        w_next = ST_SETTLE;
      ST_SETTLE:
        w_next = ST_SHOW_A;
      ST_SHOW_A:
        if (bus.LOAD)  w_next = ST_CAPTURE;
        else if (w_tc) w_next = ST_SHOW_B;
      ST_SHOW_B:
        if (bus.LOAD)  w_next = ST_CAPTURE;
        else if (w_tc) w_next = ST_SHOW_RES;
      ST_SHOW_RES:
        if (bus.LOAD)  w_next = ST_CAPTURE;
        else if (w_tc) w_next = ST_SHOW_A;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // operand capture and result latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a_reg  <= '0;
      r_b_reg  <= '0;
      r_res_eq <= 1'b0;
      r_res_gt <= 1'b0;
      r_sgn_a  <= 1'b0;
      r_sgn_b  <= 1'b0;
    end else begin
      if (r_state == ST_CAPTURE) begin
        r_a_reg <= bus.A_IN;
        r_b_reg <= bus.B_IN;
      end
      if (r_state == ST_SETTLE) begin
        r_res_eq <= bus.EQ;
        r_res_gt <= bus.GT;
        r_sgn_a  <= r_a_reg[4];
        r_sgn_b  <= r_b_reg[4];
      end
    end
  end

  // display data for the state being entered
  always_comb begin
    w_disp  = '0;
    w_valid = 1'b0;
    w_phase = PH_NONE;
    w_busy  = 1'b0;
    unique case (w_next)
      ST_CAPTURE,
      ST_SETTLE: w_busy = 1'b1;
      ST_SHOW_A: begin
        w_disp  = disp_t'{w_sgn_a, bus.A_MAG};
        w_valid = 1'b1;
        w_phase = PH_A;
      end
      ST_SHOW_B: begin
        w_disp  = disp_t'{r_sgn_b, bus.B_MAG};
        w_valid = 1'b1;
        w_phase = PH_B;
      end
      ST_SHOW_RES: begin
        w_disp  = res_disp(r_res_eq, r_res_gt);
        w_valid = 1'b1;
        w_phase = PH_RES;
      end
      default: ;
    endcase
  end

  // registered display/status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_disp_val   <= '0;
      r_disp_sign  <= 1'b0;
      r_disp_valid <= 1'b0;
      r_phase      <= PH_NONE;
      r_busy       <= 1'b0;
    end else begin
      r_disp_val   <= w_disp.val;
      r_disp_sign  <= w_disp.sign;
      r_disp_valid <= w_valid;
      r_phase      <= w_phase;
      r_busy       <= w_busy;
    end
  end

  assign bus.A_REG      = r_a_reg;
  assign bus.B_REG      = r_b_reg;
  assign bus.DISP_VAL   = r_disp_val;
  assign bus.DISP_SIGN  = r_disp_sign;
  assign bus.DISP_VALID = r_disp_valid;
  assign bus.PHASE      = r_phase;
  assign bus.BUSY       = r_busy;

endmodule
